// File: rtl/decode_ctrl_pipe_if.sv
// Bundle between the IF/ID fetch buffer, the decode/control stage and the execute stage.
// The master drives the instruction and execute handshake; the slave is the decode stage.
interface decode_ctrl_pipe_if #(
  parameter int REG_AW   = 5,
  parameter int ALUCTL_W = 4,
  parameter int CNT_W    = 16
);
  logic [31:0]         instr_i;
  logic                instr_valid_i;
  logic                instr_ready_o;
  logic                ex_ready_i;
  logic                flush_i;
  logic                valid_o;
  logic                alusrc_o;
  logic                regwrite_o;
  logic                memread_o;
  logic                memwrite_o;
  logic                branch_o;
  logic                j_o;
  logic                jalr_o;
  logic [1:0]          shift_o;
  logic [ALUCTL_W-1:0] aluctl_o;
  logic [2:0]          compare_o;
  logic [REG_AW-1:0]   rs1_o;
  logic [REG_AW-1:0]   rs2_o;
  logic [REG_AW-1:0]   rd_o;
  logic                illegal_o;
  logic [CNT_W-1:0]    stall_cnt_o;

  modport master (
    output instr_i, instr_valid_i, ex_ready_i, flush_i,
    input  instr_ready_o, valid_o, alusrc_o, regwrite_o, memread_o, memwrite_o,
           branch_o, j_o, jalr_o, shift_o, aluctl_o, compare_o, rs1_o, rs2_o, rd_o,
           illegal_o, stall_cnt_o
  );

  modport slave (
    input  instr_i, instr_valid_i, ex_ready_i, flush_i,
    output instr_ready_o, valid_o, alusrc_o, regwrite_o, memread_o, memwrite_o,
           branch_o, j_o, jalr_o, shift_o, aluctl_o, compare_o, rs1_o, rs2_o, rd_o,
           illegal_o, stall_cnt_o
  );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// Registered RV32I decode/control stage (ID/EX register) with load-use bubbles and flush.
// Optional macro UPPER_IMM_DECODE_EN adds lui/auipc decode; otherwise both are illegal.
module decode_ctrl_pipe #(
  parameter int REG_AW   = 5,
  parameter int ALUCTL_W = 4,
  parameter int CNT_W    = 16
) (
  input logic                clk_i,
  input logic                rst_i,
  decode_ctrl_pipe_if.slave  bus
);
  typedef struct packed {
    logic                alusrc;
    logic                regwrite;
    logic                memread;
    logic                memwrite;
    logic                branch;
    logic                j;
    logic                jalr;
    logic [1:0]          shift;
    logic [ALUCTL_W-1:0] aluctl;
    logic [2:0]          compare;
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
    logic [REG_AW-1:0]   rd;
    logic                illegal;
  } ctrl_t;

  ctrl_t            ctrl_q, ctrl_d, dec;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reads_rs1, reads_rs2;
  logic [3:0]       alu4;
  logic             adv, haz;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = bus.instr_i[6:0];
  assign funct3 = bus.instr_i[14:12];
  assign funct7 = bus.instr_i[31:25];

  // ALU operation selected by funct3 for R-type and I-ALU; sub only exists for R-type
  always_comb begin
    case (funct3)
      3'b000:  alu4 = (opcode == 7'h33 && funct7 == 7'h20) ? 4'b0110 : 4'b0010;
      3'b001:  alu4 = 4'b1000;
      3'b101:  alu4 = funct7[5] ? 4'b1010 : 4'b1001;
      3'b111:  alu4 = 4'b0000;
      3'b110:  alu4 = 4'b0001;
      3'b100:  alu4 = 4'b0011;
      3'b010:  alu4 = 4'b0111;
      default: alu4 = 4'b0010;
    endcase
  end

  always_comb begin
    dec       = '0;
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    dec.rs1   = REG_AW'(bus.instr_i[19:15]);
    dec.rs2   = REG_AW'(bus.instr_i[24:20]);
    dec.rd    = REG_AW'(bus.instr_i[11:7]);
    dec.aluctl = ALUCTL_W'(4'b0010);
    case (opcode)
      7'h33: begin
        dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluctl = ALUCTL_W'(alu4);
        reads_rs1 = 1'b1; reads_rs2 = 1'b1;
      end
      7'h13: begin
        dec.regwrite = 1'b1; dec.aluctl = ALUCTL_W'(alu4);
        dec.shift = (funct3 == 3'b001) ? 2'b11 : (funct3 == 3'b101) ? 2'b10 : 2'b00;
        reads_rs1 = 1'b1;
      end
      7'h03: begin
        dec.regwrite = 1'b1; dec.memread = 1'b1; reads_rs1 = 1'b1;
      end
      7'h23: begin
        dec.memwrite = 1'b1; reads_rs1 = 1'b1; reads_rs2 = 1'b1;
      end
      7'h63: begin
        dec.alusrc = 1'b1; dec.branch = 1'b1; dec.compare = funct3;
        dec.aluctl = ALUCTL_W'(4'b0110);
        reads_rs1 = 1'b1; reads_rs2 = 1'b1;
      end
      7'h6F: begin
        dec.j = 1'b1; dec.regwrite = 1'b1;
      end
      7'h67: begin
        dec.jalr = 1'b1; dec.regwrite = 1'b1; reads_rs1 = 1'b1;
      end
`ifdef UPPER_IMM_DECODE_EN
      7'h37: begin
        dec.regwrite = 1'b1; dec.rs1 = '0;
      end
      7'h17: begin
        dec.regwrite = 1'b1;
      end
`endif
      default: begin
        // illegal word carries no control and no ALU op, only the flag
        dec.illegal = 1'b1;
        dec.aluctl  = '0;
      end
    endcase
  end

  assign adv = !valid_q || bus.ex_ready_i;
  assign haz = valid_q && ctrl_q.memread && (ctrl_q.rd != '0) && bus.instr_valid_i &&
               ((reads_rs1 && dec.rs1 == ctrl_q.rd) || (reads_rs2 && dec.rs2 == ctrl_q.rd));

  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (bus.flush_i) begin
      valid_d = 1'b0;
    end else if (adv && haz) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (adv && bus.instr_valid_i) begin
      valid_d = 1'b1;
      ctrl_d  = dec;
    end else if (adv) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.instr_ready_o = bus.flush_i || (adv && !haz);
  assign bus.valid_o       = valid_q;
  assign bus.alusrc_o      = ctrl_q.alusrc;
  assign bus.regwrite_o    = ctrl_q.regwrite;
  assign bus.memread_o     = ctrl_q.memread;
  assign bus.memwrite_o    = ctrl_q.memwrite;
  assign bus.branch_o      = ctrl_q.branch;
  assign bus.j_o           = ctrl_q.j;
  assign bus.jalr_o        = ctrl_q.jalr;
  assign bus.shift_o       = ctrl_q.shift;
  assign bus.aluctl_o      = ctrl_q.aluctl;
  assign bus.compare_o     = ctrl_q.compare;
  assign bus.rs1_o         = ctrl_q.rs1;
  assign bus.rs2_o         = ctrl_q.rs2;
  assign bus.rd_o          = ctrl_q.rd;
  assign bus.illegal_o     = ctrl_q.illegal;
  assign bus.stall_cnt_o   = cnt_q;
endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
Registered RV32I decode/control stage sitting between the fetch buffer (IF/ID) and the execute stage; it replaces the purely combinational control decoder. It decodes the opcode, funct3 and funct7 fields of the incoming instruction into the ALU, shift, branch, jump and memory control word, and holds that word in an ID/EX output register. It also performs valid/ready flow control, load-use hazard stalls with bubble insertion, branch flush and saturating stall counting.

Parameters:
REG_AW, 5, register-address width of rs1_o, rs2_o and rd_o
ALUCTL_W, 4, width of aluctl_o (minimum 4)
CNT_W, 16, width of the saturating stall counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
instr_i  in  32  instruction from IF/ID
instr_valid_i  in  1  instr_i is valid
instr_ready_o  out  1  stage accepts instr_i this cycle
ex_ready_i  in  1  execute stage accepts the output register
flush_i  in  1  branch/jump redirect; kill the in-flight instruction
valid_o  out  1  output register holds a valid instruction
alusrc_o  out  1  1 = operand B from rs2, 0 = operand B from immediate
regwrite_o  out  1  writes rd
memread_o  out  1  load
memwrite_o  out  1  store
branch_o, j_o, jalr_o  out  1 each  branch, jal, jalr
shift_o  out  2  11 = sll, 10 = srl/sra, 00 = none
aluctl_o  out  ALUCTL_W  ALU operation
compare_o  out  3  branch funct3; 000 for non-branches
rs1_o, rs2_o, rd_o  out  REG_AW each  instr_i[19:15], instr_i[24:20], instr_i[11:7]
illegal_o  out  1  unsupported opcode
stall_cnt_o  out  CNT_W  number of bubble cycles inserted for hazards

Behaviour:
- Reset (synchronous, rst_i high at a clock edge): every registered output is 0, including valid_o and stall_cnt_o. rst_i has priority over all other inputs and aborts any stall in progress.
- Opcode decode:
  - 0x33 (R-type): alusrc=1, regwrite=1.
  - 0x13 (I-ALU): alusrc=0, regwrite=1.
  - 0x03 (load): alusrc=0, regwrite=1, memread=1.
  - 0x23 (store): alusrc=0, memwrite=1.
  - 0x63 (branch): alusrc=1, branch=1, compare=funct3.
  - 0x6F (jal): j=1, regwrite=1.
  - 0x67 (jalr): alusrc=0, jalr=1, regwrite=1.
  - Any other opcode: illegal=1 with all other control bits 0; valid_o still asserts.
- aluctl encoding:
  - add = 0010 (load, store, jalr, addi, R-type funct3 000 with funct7 00).
  - sub = 0110 (branch, and R-type funct3 000 with funct7 0x20).
  - and = 0000, or = 0001, xor = 0011, slt = 0111 (R-type and I-ALU, by funct3).
  - sll = 1000, srl = 1001, sra = 1010 (sra when funct7[5]=1).
  - All unlisted combinations produce add. Upper bits are zero when ALUCTL_W > 4.
- shift_o: 11 for funct3 001 and 10 for funct3 101, only when the opcode is 0x13; otherwise 00.
- Load enable: adv = !valid_o || ex_ready_i. The output register loads only when adv is high.
- Load-use hazard (haz) is asserted when all of the following hold: valid_o, memread_o, rd_o != 0, instr_valid_i, and instr_i reads rd_o. rs1 is read by 0x33/0x13/0x03/0x23/0x63/0x67; rs2 is read by 0x33/0x23/0x63.
- instr_ready_o = flush_i || (adv && !haz).
- Priority at each clock edge, in order:
  1. rst_i.
  2. flush_i: valid_o <= 0 and the current instr_i is consumed and discarded.
  3. adv && haz: bubble, valid_o <= 0, all control bits 0, stall_cnt_o increments (saturates at all-ones).
  4. adv && instr_valid_i: load the decoded word, valid_o <= 1.
  5. adv && !instr_valid_i: valid_o <= 0.
  6. Otherwise: hold all outputs.
- A hazard costs exactly one bubble; on the following cycle the load has left the register and haz is low.
- Latency: one cycle from acceptance to valid_o.
- Full throughput: with ex_ready_i held at 1, one instruction is accepted per cycle.
- Outputs are stable while valid_o && !ex_ready_i.

Optional Feature:
UPPER_IMM_DECODE_EN.
- Defined: 0x37 (lui) decodes as alusrc=0, regwrite=1, aluctl=add, with rs1_o forced to 0. 0x17 (auipc) decodes as alusrc=0, regwrite=1, aluctl=add. Neither asserts illegal_o, and neither counts as reading rs1 or rs2 for hazard purposes.
- Undefined: both opcodes decode as illegal.

Test Plan:
- Reset: hold rst_i for 2 cycles with instr_valid_i=1 -> valid_o=0, stall_cnt_o=0, all control outputs 0.
- Stream with ex_ready_i=1: add 0x002081B3, then sub 0x402081B3, then or 0x0020E1B3 -> aluctl_o 0010, 0110, 0001 on consecutive cycles; regwrite_o=1, alusrc_o=1 for each.
- Load-use: lw x5 0x0002A283, then add x6,x5,x1 0x00128333 -> one bubble cycle with valid_o=0 and instr_ready_o=0 for one cycle; stall_cnt_o=1; the add appears one cycle later.
- Load to x0 (0x00002003) followed by a reader of x0 -> no bubble; stall_cnt_o stays 0.
- Back-pressure and flush: ex_ready_i=0 for 3 cycles -> outputs held, instr_ready_o=0. Then pulse flush_i -> valid_o=0 next cycle and the pending instruction is dropped.
- Illegal and shift: opcode 0x7F -> illegal_o=1, valid_o=1. srai 0x4030D093 -> shift_o=10, aluctl_o=1010, alusrc_o=0.
